prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader between a byte-stream source (UART receiver) and the single-port program/data RAM.
- Receives a framed image, assembles 16-bit words and writes them to consecutive RAM addresses while holding the CPU in reset.
- On completion, releases the CPU and passes the CPU's RAM port through unchanged.

Parameters:
- ADDR_W, 13, RAM address width; matches the CPU address bus.
- DATA_W, 16, RAM word width; fixed at 2 bytes per word.
- START_ADDR, 0, RAM address of the first loaded word.
- TIMEOUT_CYC, 1000000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; re-arms the loader from DONE/ERROR
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid&&rx_ready at posedge
- cpu_addr  in  ADDR_W  CPU RAM address
- cpu_wrEn  in  1  CPU write enable
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data to CPU; always equal to ram_rdata
- ram_addr  out  ADDR_W  RAM address
- ram_wrEn  out  1  RAM write enable; RAM writes at posedge
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- cpu_rst  out  1  reset to the CPU, active-high
- load_done  out  1  image loaded; CPU running
- load_error  out  1  frame rejected
- words_loaded  out  ADDR_W+1  words written in the current frame

Behaviour:
- Frame format: count_hi, count_lo (N words, big-endian), then N words sent hi byte first; no other framing.
- Reset values: cpu_rst=1, load_done=0, load_error=0, rx_ready=0, ram_wrEn=0, ram_addr=0, ram_wdata=0, words_loaded=0, state=IDLE.
- States and transitions:
  - IDLE: rx_ready=1. Accepted byte -> count_hi, go to HDR_LO.
  - HDR_LO: accepted byte -> count_lo.
    - N=0 -> DONE.
    - N > 2^ADDR_W-START_ADDR -> ERROR.
    - Otherwise addr=START_ADDR, go to DATA_HI.
  - DATA_HI: accepted byte -> word[15:8], go to DATA_LO.
  - DATA_LO: accepted byte -> word[7:0], go to WRITE.
  - WRITE: exactly one cycle, rx_ready=0.
    - Drives ram_wrEn=1, ram_addr=addr, ram_wdata=word.
    - Increments addr and words_loaded.
    - words_loaded+1==N -> DONE; else -> DATA_HI.
  - DONE: cpu_rst=0, load_done=1, rx_ready=0.
    - RAM port muxed to CPU: ram_addr=cpu_addr, ram_wrEn=cpu_wrEn, ram_wdata=cpu_wdata.
  - ERROR: cpu_rst=1, load_error=1, rx_ready=0. The RAM port is idle (wrEn=0).
- In all non-DONE states, the CPU port is ignored and ram_wrEn is asserted only in WRITE.
- cpu_rst, load_done and load_error are registered and change on the clock edge that enters or leaves DONE/ERROR.
- Throughput: a word completes at most once every 3 clocks (hi, lo, write).
- Timeout: in HDR_LO, DATA_HI or DATA_LO, TIMEOUT_CYC consecutive clocks without an accepted byte -> ERROR.
  - Counter clears on every accepted byte.
- start pulse:
  - In DONE or ERROR: next state IDLE, cpu_rst=1, load_done=0, load_error=0, words_loaded=0.
  - In any other state: ignored.
- rst mid-frame: immediate return to reset values; partially written RAM contents are not cleared.
- Address never wraps: guaranteed by the N range check.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- When defined:
  - A CHECK state follows the last WRITE and accepts one trailer byte.
  - The trailer must equal the 8-bit two's-complement of the modulo-256 sum of all preceding frame bytes (header included). Match -> DONE; mismatch -> ERROR.
  - Timeout also applies in CHECK.
  - For N=0, HDR_LO goes to CHECK instead of DONE.
- When undefined: no trailer byte; behaviour exactly as above.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding constants: IDLE, HDR_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
  - ADDR_W/DATA_W defaults shared with the CPU.
- Sub-module: one, ram_port_mux, a combinational select between loader and CPU RAM signals driven by the registered load_done.
- FSM, counters and checksum stay in prog_loader.

Test Plan:
- Bytes 00 03 12 34 AB CD 00 07, rx_valid always high:
  - RAM[0]=1234, RAM[1]=ABCD, RAM[2]=0007.
  - words_loaded=3, then load_done=1, cpu_rst=0.
  - rx_ready low during each WRITE cycle.
- Header 00 00 -> DONE with no RAM writes and words_loaded=0.
  - With the macro defined: trailer byte 00 required first.
- Header 20 01 (8193 words > 8192) with START_ADDR=0 -> load_error=1, cpu_rst=1, no RAM writes.
- Header 00 02, bytes 11 22, then silence for TIMEOUT_CYC clocks:
  - ERROR with RAM[0]=1122.
  - start pulse returns to IDLE; a full reload then succeeds.
- In DONE, CPU writes addr 5 data BEEF: ram_wrEn=1, ram_addr=5, and cpu_rdata follows ram_rdata.
- With the macro defined:
  - Frame 00 01 01 02 + trailer FC -> DONE.
  - Same frame + trailer FD -> ERROR.
  - rst asserted mid-frame -> all outputs return to reset values next clock.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared widths and loader state encoding.
package prog_loader_pkg;
    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {IDLE, HDR_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR} state_t;

    function automatic logic takes_byte(state_t s);
        return s inside {IDLE, HDR_LO, DATA_HI, DATA_LO, CHECK};
    endfunction

    // States that are mid-frame and therefore subject to the inter-byte timeout.
    function automatic logic watched(state_t s);
        return s inside {HDR_LO, DATA_HI, DATA_LO, CHECK};
    endfunction
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream, CPU RAM port, RAM port and load status of the loader.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_wrEn;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wrEn;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              cpu_rst;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        input  start, rx_data, rx_valid, cpu_addr, cpu_wrEn, cpu_wdata, ram_rdata,
        output rx_ready, cpu_rdata, ram_addr, ram_wrEn, ram_wdata,
               cpu_rst, load_done, load_error, words_loaded
    );

    modport slave (
        output start, rx_data, rx_valid, cpu_addr, cpu_wrEn, cpu_wdata, ram_rdata,
        input  rx_ready, cpu_rdata, ram_addr, ram_wrEn, ram_wdata,
               cpu_rst, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/prog_loader_ram_port_mux.sv
// prog_loader_ram_port_mux: hands the RAM port to the CPU once loading is done.
module prog_loader_ram_port_mux #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_wrEn,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wrEn,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wrEn,
    output logic [DATA_W-1:0] ram_wdata
);
    assign ram_addr  = sel ? cpu_addr  : ld_addr;
    assign ram_wrEn  = sel ? cpu_wrEn  : ld_wrEn;
    assign ram_wdata = sel ? cpu_wdata : ld_wdata;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed image of 16-bit words into RAM, then releases the CPU.
// Defining PROG_LOADER_CHECKSUM_EN adds a trailing two's-complement checksum byte to the frame.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int START_ADDR  = 0,
    parameter int TIMEOUT_CYC = 1000000
) (
    input logic           clk,
    input logic           rst,
    prog_loader_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned MAX_N = (32'd1 << ADDR_W) - 32'(START_ADDR);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t FINAL = CHECK;
`else
    localparam state_t FINAL = DONE;
`endif

    state_t            state, state_n;
    logic [7:0]        count_hi, word_hi;
    logic [15:0]       count, hdr;
    logic [DATA_W-1:0] word, ld_wdata;
    logic [ADDR_W-1:0] addr, ld_addr;
    logic [TW-1:0]     idle_cnt;
    logic              acc, expired, last, ld_wr;

    assign bus.rx_ready  = !rst && takes_byte(state);
    assign acc           = bus.rx_valid && bus.rx_ready;
    assign hdr           = {count_hi, bus.rx_data};
    assign expired       = watched(state) && !acc && idle_cnt == TW'(TIMEOUT_CYC - 1);
    assign last          = 32'(bus.words_loaded) + 32'd1 == 32'(count);
    assign ld_wr         = state == WRITE;
    assign ld_addr       = ld_wr ? addr : '0;
    assign ld_wdata      = ld_wr ? word : '0;
    assign bus.cpu_rdata = bus.ram_rdata;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic       sum_ok;
    // Adding the trailer to the running sum of all earlier bytes must give zero.
    assign sum_ok = 8'(sum + bus.rx_data) == 8'h00;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:        state_n = acc ? HDR_LO : IDLE;
            HDR_LO:      state_n = acc ? (hdr == 16'd0 ? FINAL : 32'(hdr) > MAX_N ? ERROR : DATA_HI)
                                       : expired ? ERROR : HDR_LO;
            DATA_HI:     state_n = acc ? DATA_LO : expired ? ERROR : DATA_HI;
            DATA_LO:     state_n = acc ? WRITE : expired ? ERROR : DATA_LO;
            WRITE:       state_n = last ? FINAL : DATA_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK:       state_n = acc ? (sum_ok ? DONE : ERROR) : expired ? ERROR : CHECK;
`endif
            DONE, ERROR: state_n = bus.start ? IDLE : state;
            default:     state_n = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            count_hi         <= '0;
            count            <= '0;
            word_hi          <= '0;
            word             <= '0;
            addr             <= '0;
            idle_cnt         <= '0;
            bus.words_loaded <= '0;
            bus.cpu_rst      <= 1'b1;
            bus.load_done    <= 1'b0;
            bus.load_error   <= 1'b0;
        end else begin
            state          <= state_n;
            idle_cnt       <= watched(state) && !acc ? idle_cnt + 1'b1 : '0;
            bus.cpu_rst    <= state_n != DONE;
            bus.load_done  <= state_n == DONE;
            bus.load_error <= state_n == ERROR;
            if (acc && state == IDLE) count_hi <= bus.rx_data;
            if (acc && state == HDR_LO) begin
                count <= hdr;
                addr  <= ADDR_W'(START_ADDR);
            end
            if (acc && state == DATA_HI) word_hi <= bus.rx_data;
            if (acc && state == DATA_LO) word <= DATA_W'({word_hi, bus.rx_data});
            if (ld_wr) begin
                addr             <= addr + 1'b1;
                bus.words_loaded <= bus.words_loaded + 1'b1;
            end
            if ((state == DONE || state == ERROR) && bus.start) bus.words_loaded <= '0;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) sum <= '0;
        else if (acc) sum <= (state == IDLE ? 8'h00 : sum) + bus.rx_data;
    end
`endif

    prog_loader_ram_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .sel      (bus.load_done),
        .ld_addr  (ld_addr),
        .ld_wrEn  (ld_wr),
        .ld_wdata (ld_wdata),
        .cpu_addr (bus.cpu_addr),
        .cpu_wrEn (bus.cpu_wrEn),
        .cpu_wdata(bus.cpu_wdata),
        .ram_addr (bus.ram_addr),
        .ram_wrEn (bus.ram_wrEn),
        .ram_wdata(bus.ram_wdata)
    );
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: frame table, directed corner sequences and random frames checked against a frame-level model.
module tb_prog_loader;
    localparam int AW = 13, DW = 16, START = 0, TMO = 40;
    localparam int MAXN = (1 << AW) - START;

    typedef logic [7:0] bq_t[$];
    typedef logic [15:0] wq_t[$];
    typedef struct {
        int n;
        bit bad;
        bit hdr_only;
        bit exp_done;
    } vec_t;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    prog_loader #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(START), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] ram [0:(1<<AW)-1];
    int wr_total = 0, bad_rdy = 0;
    assign bus.ram_rdata = ram[bus.ram_addr];
    always @(posedge clk) begin
        if (bus.ram_wrEn) ram[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_wrEn && !bus.load_done) wr_total <= wr_total + 1;
        if (bus.ram_wrEn && !bus.load_done && bus.rx_ready) bad_rdy <= bad_rdy + 1;
    end

    int n_chk = 0, n_pass = 0;
    bit gaps = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        if (gaps) repeat ($urandom_range(0, 3)) begin
            bus.rx_valid = 0;
            bus.rx_data  = 8'($urandom);
            tick();
        end
        bus.rx_data  = b;
        bus.rx_valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.rx_ready;
            tick();
        end
        if (!ok) check("rx_accept", 32'(ok), 1);
    endtask

    function automatic bq_t seal(input bq_t q);
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] s = 0;
        foreach (q[i]) s += q[i];
        q.push_back(8'(-s));
`endif
        return q;
    endfunction

    function automatic bq_t make(input int n, input int nwords);
        bq_t q = {8'(n >> 8), 8'(n)};
        for (int i = 0; i < 2 * nwords; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Frame-level reference: header range rule, words in order, optional zero-sum trailer.
    function automatic void model(input bq_t f, output bit ok, output wq_t w);
        int n;
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] s = 0;
`endif
        n  = int'({f[0], f[1]});
        w  = {};
        ok = 0;
        if (n > MAXN) return;
        for (int i = 0; i < n; i++) w.push_back({f[2+2*i], f[3+2*i]});
        ok = 1;
`ifdef PROG_LOADER_CHECKSUM_EN
        foreach (f[i]) s += f[i];
        ok = s == 8'h00;
`endif
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, " cpu_rst"}, 32'(bus.cpu_rst), 1);
        check({tag, " load_done"}, 32'(bus.load_done), 0);
        check({tag, " load_error"}, 32'(bus.load_error), 0);
        check({tag, " rx_ready"}, 32'(bus.rx_ready), 0);
        check({tag, " ram_wrEn"}, 32'(bus.ram_wrEn), 0);
        check({tag, " ram_addr"}, 32'(bus.ram_addr), 0);
        check({tag, " ram_wdata"}, 32'(bus.ram_wdata), 0);
        check({tag, " words"}, 32'(bus.words_loaded), 0);
    endtask

    task automatic rearm;
        if (bus.load_done || bus.load_error) begin
            bus.start = 1;
            tick();
            bus.start = 0;
            check("rearm load_done", 32'(bus.load_done), 0);
            check("rearm load_error", 32'(bus.load_error), 0);
            check("rearm cpu_rst", 32'(bus.cpu_rst), 1);
            check("rearm words", 32'(bus.words_loaded), 0);
            check("rearm rx_ready", 32'(bus.rx_ready), 1);
        end
    endtask

    task automatic wait_end;
        int k = 0;
        while (!(bus.load_done || bus.load_error) && k < 200) begin
            tick();
            k++;
        end
        check("end_wait", 32'(bus.load_done || bus.load_error), 1);
    endtask

    task automatic run_frame(input string name, input bq_t f, input bit exp_done);
        wq_t w;
        bit ok;
        int base, mism = 0;
        model(f, ok, w);
        rearm();
        base = wr_total;
        foreach (f[i]) send_byte(f[i]);
        bus.rx_valid = 0;
        wait_end();
        check({name, " load_done"}, 32'(bus.load_done), 32'(exp_done));
        check({name, " load_error"}, 32'(bus.load_error), 32'(!exp_done));
        check({name, " cpu_rst"}, 32'(bus.cpu_rst), 32'(!exp_done));
        check({name, " words"}, 32'(bus.words_loaded), 32'(w.size()));
        check({name, " writes"}, 32'(wr_total - base), 32'(w.size()));
        foreach (w[i]) if (ram[START+i] !== w[i]) mism++;
        check({name, " mem"}, 32'(mism), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        bq_t q;
        wq_t w;
        bit ok;
        int k;
        bus.start = 0;
        bus.rx_valid = 0;
        bus.rx_data = 0;
        bus.cpu_addr = 0;
        bus.cpu_wrEn = 0;
        bus.cpu_wdata = 0;
        rst = 1;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 0;
        #1;
        check("idle rx_ready", 32'(bus.rx_ready), 1);
        bus.cpu_addr = 7;
        bus.cpu_wrEn = 1;
        bus.cpu_wdata = 16'h1111;
        #1;
        check("idle cpu ignored wrEn", 32'(bus.ram_wrEn), 0);
        check("idle cpu ignored addr", 32'(bus.ram_addr), 0);
        bus.cpu_wrEn = 0;
        bus.cpu_addr = 0;
        tick();

        q = seal({8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07});
        run_frame("plan", q, 1);
        check("plan ram0", 32'(ram[0]), 32'h1234);
        check("plan ram1", 32'(ram[1]), 32'hABCD);
        check("plan ram2", 32'(ram[2]), 32'h0007);
        check("plan rx_ready low in write", 32'(bad_rdy), 0);

        bus.cpu_addr = 5;
        bus.cpu_wdata = 16'hBEEF;
        bus.cpu_wrEn = 1;
        #1;
        check("cpu ram_wrEn", 32'(bus.ram_wrEn), 1);
        check("cpu ram_addr", 32'(bus.ram_addr), 5);
        check("cpu ram_wdata", 32'(bus.ram_wdata), 32'hBEEF);
        tick();
        bus.cpu_wrEn = 0;
        #1;
        check("cpu rdata", 32'(bus.cpu_rdata), 32'hBEEF);

        vecs.push_back('{n: 0, bad: 0, hdr_only: 0, exp_done: 1});
        vecs.push_back('{n: 1, bad: 0, hdr_only: 0, exp_done: 1});
        vecs.push_back('{n: 2, bad: 0, hdr_only: 0, exp_done: 1});
        vecs.push_back('{n: 8193, bad: 0, hdr_only: 1, exp_done: 0});
        vecs.push_back('{n: 16'hFFFF, bad: 0, hdr_only: 1, exp_done: 0});
        vecs.push_back('{n: 8192, bad: 0, hdr_only: 0, exp_done: 1});
`ifdef PROG_LOADER_CHECKSUM_EN
        vecs.push_back('{n: 4, bad: 1, hdr_only: 0, exp_done: 0});
        vecs.push_back('{n: 0, bad: 1, hdr_only: 0, exp_done: 0});
`endif
        foreach (vecs[i]) begin
            q = make(vecs[i].n, vecs[i].hdr_only ? 0 : vecs[i].n);
            if (!vecs[i].hdr_only) q = seal(q);
`ifdef PROG_LOADER_CHECKSUM_EN
            if (vecs[i].bad) q[q.size()-1] ^= 8'h01;
`endif
            run_frame($sformatf("vec%0d", i), q, vecs[i].exp_done);
        end

`ifdef PROG_LOADER_CHECKSUM_EN
        run_frame("sum good", {8'h00, 8'h01, 8'h01, 8'h02, 8'hFC}, 1);
        check("sum good ram0", 32'(ram[0]), 32'h0102);
        run_frame("sum bad", {8'h00, 8'h01, 8'h01, 8'h02, 8'hFD}, 0);
`endif

        rearm();
        foreach (q[i]) q.delete(i);
        q = {8'h00, 8'h02, 8'h11, 8'h22};
        foreach (q[i]) send_byte(q[i]);
        bus.rx_valid = 0;
        k = 0;
        while (!bus.load_error && k < 200) begin
            tick();
            k++;
        end
        check("timeout error", 32'(bus.load_error), 1);
        check("timeout latency", 32'(k >= TMO && k <= TMO + 2), 1);
        check("timeout cpu_rst", 32'(bus.cpu_rst), 1);
        check("timeout ram0", 32'(ram[0]), 32'h1122);
        check("timeout words", 32'(bus.words_loaded), 1);
        run_frame("reload", seal(make(2, 2)), 1);

        gaps = 1;
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 24);
            q = seal(make(n, n));
`ifdef PROG_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) q[q.size()-1] ^= 8'($urandom_range(1, 255));
`endif
            model(q, ok, w);
            run_frame($sformatf("rand%0d", r), q, ok);
        end
        gaps = 0;

        rearm();
        q = {8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
        foreach (q[i]) send_byte(q[i]);
        check("midrst pre words", 32'(bus.words_loaded), 1);
        rst = 1;
        bus.cpu_wrEn = 1;
        bus.cpu_addr = 9;
        tick();
        check_reset_vals("midrst");
        bus.cpu_wrEn = 0;
        bus.rx_valid = 0;
        rst = 0;
        #1;
        check("midrst ram0 kept", 32'(ram[0]), 32'hAABB);
        run_frame("post reset", seal(make(3, 3)), 1);
        check("rx_ready low in all writes", 32'(bad_rdy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
